uart_hello_checker: RTL



---
 rtl/uart_test_pkg.sv | 33 +++
 rtl/uart_byte_timer.sv | 37 +++
 rtl/uart_hello_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_test_pkg.sv
// Shared definitions for the UART "HELLO\r\n" link test.
// Holds the message length, the expected byte sequence (also used by the
// transmitter side), the checker state encoding and the default UART divider.
package uart_test_pkg;

    localparam int HELLO_LEN         = 7;
    localparam int UART_CLOCK_DIVIDE = 1302;

    // First byte of every message; also the resync trigger.
    localparam logic [7:0] HELLO_START = 8'd72;

    // "HELLO\r\n", element 0 is sent first.
    localparam logic [0:HELLO_LEN-1][7:0] HELLO_SEQ = {
        8'd72, 8'd69, 8'd76, 8'd76, 8'd79, 8'd13, 8'd10
    };

    typedef enum logic {
        HUNT  = 1'b0,
        MATCH = 1'b1
    } check_state_t;

    // Expected byte at message position pos; positions past the end
    // return 0, which never matches a legal message byte.
    function automatic logic [7:0] hello_byte(input logic [2:0] pos);
        logic [7:0] b;
        b = 8'h00;
        if (int'(pos) < HELLO_LEN) begin
            b = HELLO_SEQ[pos];
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Inter-byte timeout counter for the HELLO checker.
// Counts enabled cycles since the last clear and raises expired for one
// cycle when the count reaches TIMEOUT-1, then restarts from zero.
//
// Ports:
//   clk     - system clock
//   reset   - synchronous active-high reset
//   clear   - restart the count (has priority over enable)
//   enable  - count this cycle
//   expired - one-cycle pulse: inter-byte gap limit reached
module uart_byte_timer #(
    parameter int TIMEOUT = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // A clear in the same cycle (byte arrived) suppresses the timeout.
    assign expired = enable && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || expired) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/uart_hello_checker.sv
// Receive-side checker for the periodic "HELLO\r\n" link test.
// Matches the uart byte stream against the expected 7-byte message, counts
// good and bad messages (saturating), declares lock after LOCK_COUNT
// consecutive good messages and shows status on the board LEDs.
//
// Ports:
//   clk        - system clock
//   reset      - synchronous active-high reset
//   received   - one-cycle strobe: rx_byte valid
//   rx_byte    - received byte
//   recv_error - one-cycle strobe: framing error (wins over received)
//   msg_ok     - one-cycle pulse per complete correct message
//   locked     - high after LOCK_COUNT consecutive good messages
//   msg_count  - good messages, saturating
//   err_count  - errors, saturating
//   led        - {locked, idx[2:0], msg_count[3:0]}
module uart_hello_checker
    import uart_test_pkg::*;
#(
    parameter int TIMEOUT    = 50000,
    parameter int LOCK_COUNT = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             received,
    input  logic [7:0]       rx_byte,
    input  logic             recv_error,
    output logic             msg_ok,
    output logic             locked,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       led
);

    localparam int SW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(LOCK_COUNT);
    localparam logic [2:0]    LAST_IDX   = 3'(HELLO_LEN - 1);

    check_state_t     state, state_n;
    logic [2:0]       idx, idx_n;
    logic [SW-1:0]    streak, streak_n;
    logic             locked_n;
    logic             msg_ok_n;
    logic [CNT_W-1:0] msg_count_n;
    logic [CNT_W-1:0] err_count_n;
    logic             error_event;
    logic             good_msg;
    logic             timer_clear;
    logic             timer_enable;
    logic             expired;

    // The gap timer only runs while a message is in progress; any byte or
    // framing error restarts it.
    assign timer_clear  = (state != MATCH) || received || recv_error;
    assign timer_enable = (state == MATCH);

    uart_byte_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            idx       <= '0;
            streak    <= '0;
            locked    <= 1'b0;
            msg_ok    <= 1'b0;
            msg_count <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            streak    <= streak_n;
            locked    <= locked_n;
            msg_ok    <= msg_ok_n;
            msg_count <= msg_count_n;
            err_count <= err_count_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        streak_n    = streak;
        locked_n    = locked;
        msg_ok_n    = 1'b0;
        msg_count_n = msg_count;
        err_count_n = err_count;
        error_event = 1'b0;
        good_msg    = 1'b0;

        if (recv_error) begin
            // Framing error: any byte strobed alongside it is dropped.
            if (state == MATCH) begin
                error_event = 1'b1;
                state_n     = HUNT;
                idx_n       = '0;
            end else if (locked) begin
                error_event = 1'b1;
            end
        end else if (received) begin
            case (state)
                HUNT: begin
                    if (rx_byte == HELLO_START) begin
                        state_n = MATCH;
                        idx_n   = 3'd1;
                    end else if (locked) begin
                        // Stray bytes only count once the link was trusted.
                        error_event = 1'b1;
                    end
                end
                MATCH: begin
                    if (rx_byte == hello_byte(idx)) begin
                        if (idx == LAST_IDX) begin
                            good_msg = 1'b1;
                            state_n  = HUNT;
                            idx_n    = '0;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else begin
                        error_event = 1'b1;
                        if (rx_byte == HELLO_START) begin
                            state_n = MATCH;
                            idx_n   = 3'd1;
                        end else begin
                            state_n = HUNT;
                            idx_n   = '0;
                        end
                    end
                end
                default: begin
                    state_n = HUNT;
                    idx_n   = '0;
                end
            endcase
        end else if (expired) begin
            error_event = 1'b1;
            state_n     = HUNT;
            idx_n       = '0;
        end

        if (error_event) begin
            streak_n = '0;
            locked_n = 1'b0;
            if (err_count != '1) begin
                err_count_n = err_count + CNT_W'(1);
            end
        end

        if (good_msg) begin
            msg_ok_n = 1'b1;
            if (msg_count != '1) begin
                msg_count_n = msg_count + CNT_W'(1);
            end
            if (streak != STREAK_MAX) begin
                streak_n = streak + SW'(1);
            end
            if (streak_n == STREAK_MAX) begin
                locked_n = 1'b1;
            end
        end
    end

    assign led = {locked, idx, msg_count[3:0]};

endmodule
